// File: rtl/frame_render_sequencer.sv
// Per-frame controller for the wireframe pipeline: on an accepted frame tick it
// latches the angle and runs clear, sin/cos, per-vertex transform and per-edge draw.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   enable                accept frame ticks while idle
//   frame_clk_rising_edge one-cycle frame tick
//   theta_in              current angle (4.8 fixed point)
//   clear_start/done      framebuffer clear handshake (start pulse / done pulse)
//   trig_start/angle/done sin/cos handshake with latched frame angle
//   xform_start/vidx/done per-vertex transform handshake
//   draw_req/eidx/ack     per-edge draw valid/ready transfer
//   frame_busy            high whenever not idle
//   frame_done            one-cycle end-of-frame pulse
//   overrun_cnt           saturating count of ticks dropped mid-frame
module frame_render_sequencer #(
    parameter int ANGLE_W   = 12,
    parameter int NUM_VERTS = 8,
    parameter int VIDX_W    = 3,
    parameter int NUM_EDGES = 12,
    parameter int EIDX_W    = 4,
    parameter int OVR_W     = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               enable,
    input  logic               frame_clk_rising_edge,
    input  logic [ANGLE_W-1:0] theta_in,
    output logic               clear_start,
    input  logic               clear_done,
    output logic               trig_start,
    output logic [ANGLE_W-1:0] trig_angle,
    input  logic               trig_done,
    output logic               xform_start,
    output logic [VIDX_W-1:0]  xform_vidx,
    input  logic               xform_done,
    output logic               draw_req,
    output logic [EIDX_W-1:0]  draw_eidx,
    input  logic               draw_ack,
    output logic               frame_busy,
    output logic               frame_done,
    output logic [OVR_W-1:0]   overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TRIG,
        S_XFORM,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [VIDX_W-1:0] VLAST = VIDX_W'(NUM_VERTS - 1);
    localparam logic [EIDX_W-1:0] ELAST = EIDX_W'(NUM_EDGES - 1);

    state_t state;
    state_t state_nxt;

    logic               tick_ok;
    logic               clr_fire;
    logic               trig_fire;
    logic               xf_fire;
    logic               dr_fire;
    logic               v_last;
    logic               e_last;

    logic               clear_start_d;
    logic               trig_start_d;
    logic [ANGLE_W-1:0] trig_angle_d;
    logic               xform_start_d;
    logic [VIDX_W-1:0]  xform_vidx_d;
    logic               draw_req_d;
    logic [EIDX_W-1:0]  draw_eidx_d;
    logic               frame_busy_d;
    logic               frame_done_d;
    logic [OVR_W-1:0]   overrun_cnt_d;

    // A done pulse coincident with its own start pulse belongs to a
    // previous request, so it is masked by the registered start.
    assign tick_ok   = frame_clk_rising_edge & enable & (state == S_IDLE);
    assign clr_fire  = (state == S_CLEAR) & ~clear_start & clear_done;
    assign trig_fire = (state == S_TRIG) & ~trig_start & trig_done;
    assign xf_fire   = (state == S_XFORM) & ~xform_start & xform_done;
    assign dr_fire   = (state == S_DRAW) & draw_req & draw_ack;
    assign v_last    = (xform_vidx == VLAST);
    assign e_last    = (draw_eidx == ELAST);

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            clear_start <= 1'b0;
            trig_start  <= 1'b0;
            trig_angle  <= '0;
            xform_start <= 1'b0;
            xform_vidx  <= '0;
            draw_req    <= 1'b0;
            draw_eidx   <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state       <= state_nxt;
            clear_start <= clear_start_d;
            trig_start  <= trig_start_d;
            trig_angle  <= trig_angle_d;
            xform_start <= xform_start_d;
            xform_vidx  <= xform_vidx_d;
            draw_req    <= draw_req_d;
            draw_eidx   <= draw_eidx_d;
            frame_busy  <= frame_busy_d;
            frame_done  <= frame_done_d;
            overrun_cnt <= overrun_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (tick_ok) state_nxt = S_CLEAR;
            S_CLEAR: if (clr_fire) state_nxt = S_TRIG;
            S_TRIG:  if (trig_fire) state_nxt = S_XFORM;
            S_XFORM: if (xf_fire && v_last) state_nxt = S_DRAW;
            S_DRAW:  if (dr_fire && e_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        clear_start_d = tick_ok;
        trig_start_d  = clr_fire;
        xform_start_d = trig_fire | (xf_fire & ~v_last);
        trig_angle_d  = tick_ok ? theta_in : trig_angle;

        xform_vidx_d = xform_vidx;
        if (trig_fire)
            xform_vidx_d = '0;
        else if (xf_fire && !v_last)
            xform_vidx_d = xform_vidx + VIDX_W'(1);

        draw_req_d  = draw_req;
        draw_eidx_d = draw_eidx;
        if (xf_fire && v_last) begin
            draw_req_d  = 1'b1;
            draw_eidx_d = '0;
        end else if (dr_fire) begin
            if (e_last)
                draw_req_d = 1'b0;
            else
                draw_eidx_d = draw_eidx + EIDX_W'(1);
        end

        frame_busy_d = (state_nxt != S_IDLE);
        frame_done_d = (state_nxt == S_DONE);

        // Any tick outside IDLE is dropped and counted, saturating
        overrun_cnt_d = overrun_cnt;
        if (frame_clk_rising_edge && (state != S_IDLE) && (overrun_cnt != '1))
            overrun_cnt_d = overrun_cnt + OVR_W'(1);
    end

endmodule
